ifetch_ctrl: RTL
================

Name: ifetch_ctrl

Overview:
- Drives the load side of the PC register and consumes its output to fetch instructions from instruction memory.
- Presents each fetched word to decode through a valid/ready handshake.
- Advances the PC by PC_STEP on every completed fetch and applies redirects (branch/jump) from later stages.
- Single outstanding memory read; one-entry instruction holding register.

Parameters:
- WIDTH, 32, PC/address/instruction width.
- RESET_PC, 32'h00000060, PC value forced while rst is high.
- PC_STEP, 4, PC increment per fetched instruction.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous active-high reset.
- pc_out  in  WIDTH  current PC from the PC register.
- pc_load  out  1  load strobe to the PC register.
- pc_in  out  WIDTH  value written to the PC register when pc_load=1.
- mem_read  out  1  instruction memory read request.
- mem_address  out  WIDTH  read address; bits [1:0] always 0.
- mem_resp  in  1  one-cycle read-complete pulse.
- mem_rdata  in  WIDTH  read data, valid when mem_resp=1.
- instr_valid  out  1  instr/instr_pc hold a valid instruction.
- instr_ready  in  1  decode accepts the instruction this cycle.
- instr  out  WIDTH  fetched instruction word.
- instr_pc  out  WIDTH  PC of instr.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  WIDTH  new fetch PC.

Behaviour:
- States: REQ (read outstanding), HOLD (instruction buffered), DRAIN (read outstanding, result to be discarded).
- Reset:
  - While rst=1: state←REQ, pc_load=1, pc_in=RESET_PC, mem_read=0, instr_valid=0, instr=0, instr_pc=0, addr_q=0.
  - First cycle after reset: mem_read=1, mem_address=RESET_PC.
- REQ:
  - mem_read=1, mem_address={pc_out[WIDTH-1:2],2'b00}; addr_q←that address every cycle.
  - On mem_resp: instr←mem_rdata, instr_pc←pc_out, pc_load=1, pc_in=pc_out+PC_STEP (modulo 2^WIDTH, wraps silently), then →HOLD.
  - Latency: instr_valid rises the cycle after mem_resp.
- HOLD:
  - mem_read=0, instr_valid=1; instr/instr_pc stable while instr_ready=0.
  - instr_ready=1: handshake completes, instr_valid=0 next cycle, →REQ. The next read issues the cycle after acceptance, at the already-incremented PC.
- DRAIN:
  - mem_read=1, mem_address=addr_q; address held stable until mem_resp.
  - mem_resp: data dropped, →REQ.
- Memory protocol:
  - Once mem_read is asserted it is never deasserted, and mem_address never changes, until mem_resp (except on rst).
  - mem_resp outside REQ/DRAIN is ignored.
- Redirect (priority over increment; pc_in=redirect_pc, pc_load=1 that cycle):
  - REQ, no mem_resp: →DRAIN.
  - REQ with mem_resp same cycle: data dropped, no increment, →REQ.
  - HOLD: instr_valid=0 next cycle, →REQ. If instr_ready=1 the same cycle, that handshake still counts as completed.
  - DRAIN: PC reloaded again; stays DRAIN until mem_resp.
- pc_load=0 in all other cycles.
- Reset mid-operation: rst wins over every event; any outstanding read is abandoned (memory is reset by the same rst).
- Throughput: at most one instruction per 2 cycles (REQ→HOLD→REQ with 1-cycle memory and ready=1).

Decomposition:
- Shared package: fetch_state_t enum {REQ, HOLD, DRAIN}, RESET_PC and PC_STEP constants (also used by the top-level datapath).
- No sub-module. The existing PC register stays external, and the incrementer is one adder inside.

Test Plan:
- Reset then 1-cycle memory, ready=1 → reads at 0x60, 0x64, 0x68; pc_in=0x64, 0x68, 0x6C; instr_pc matches each address.
- HOLD with instr_ready=0 for 5 cycles → instr/instr_pc stable, mem_read=0, no pc_load; ready=1 → next read at 0x64.
- Redirect to 0x200 while a read of 0x60 is pending (mem_resp at +3) → pc_in=0x200 immediately; mem_address stays 0x60 until resp; data dropped, instr_valid stays 0; next read at 0x200.
- Redirect to 0x300 in the same cycle as mem_resp → pc_in=0x300 (not 0x64), no instr_valid, next read at 0x300.
- PC=0xFFFFFFFC fetch completes → pc_in=0x00000000 (wrap).
- rst asserted during REQ and during HOLD → next cycle instr_valid=0, mem_read=0, pc_in=0x60 with pc_load=1; fetch restarts at 0x60 after rst drops.

Source files
------------

// File: rtl/ifetch_ctrl_pkg.sv
// Shared types and reset/step constants for the instruction fetch controller.
package ifetch_ctrl_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0060;
  localparam logic [31:0] FETCH_PC_STEP  = 32'd4;

endpackage

// File: rtl/ifetch_ctrl.sv
// Fetch controller: drives the external PC register, issues one read at a time
// to instruction memory, and buffers one instruction for decode.
module ifetch_ctrl
  import ifetch_ctrl_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(FETCH_RESET_PC),
  parameter logic [WIDTH-1:0] PC_STEP  = WIDTH'(FETCH_PC_STEP)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_out,
  output logic             pc_load,
  output logic [WIDTH-1:0] pc_in,
  output logic             mem_read,
  output logic [WIDTH-1:0] mem_address,
  input  logic             mem_resp,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc
);

  fetch_state_t     state;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] fetch_addr;

  assign fetch_addr  = {pc_out[WIDTH-1:2], 2'b00};
  // DRAIN replays the captured address so the memory sees a stable request.
  assign mem_address = (state == DRAIN) ? addr_q : fetch_addr;
  assign mem_read    = !rst && (state != HOLD);

  // Redirect outranks the increment; the adder wraps modulo 2^WIDTH.
  always_comb begin
    pc_load = 1'b0;
    pc_in   = pc_out + PC_STEP;
    if (rst) begin
      pc_load = 1'b1;
      pc_in   = RESET_PC;
    end else if (redirect) begin
      pc_load = 1'b1;
      pc_in   = redirect_pc;
    end else if (state == REQ && mem_resp) begin
      pc_load = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= REQ;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      addr_q      <= '0;
    end else begin
      case (state)
        REQ: begin
          addr_q <= fetch_addr;
          if (mem_resp && !redirect) begin
            instr       <= mem_rdata;
            instr_pc    <= pc_out;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end else if (redirect && !mem_resp) begin
            state <= DRAIN;
          end
        end
        HOLD: begin
          if (instr_ready || redirect) begin
            instr_valid <= 1'b0;
            state       <= REQ;
          end
        end
        DRAIN: begin
          if (mem_resp) state <= REQ;
        end
        default: state <= REQ;
      endcase
    end
  end

endmodule
